// File: rtl/fetch_unit_if.sv
// Bundles the instruction-memory, redirect and decode-side signals of the fetch unit.
// The master modport is the fetch unit; the slave modport is its environment.
interface fetch_unit_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        if_valid;
  logic        if_ready;
  logic [31:0] if_instr;
  logic [31:0] if_pc;
  logic [6:0]  opcode;
  logic [2:0]  funct_3;
  logic [6:0]  func_7;
  logic [31:0] fetch_count;

  modport master (
    output imem_req, imem_addr, if_valid, if_instr, if_pc,
           opcode, funct_3, func_7, fetch_count,
    input  imem_rvalid, imem_rdata, redirect_valid, redirect_pc, if_ready
  );

  modport slave (
    input  imem_req, imem_addr, if_valid, if_instr, if_pc,
           opcode, funct_3, func_7, fetch_count,
    output imem_rvalid, imem_rdata, redirect_valid, redirect_pc, if_ready
  );
endinterface

// File: rtl/fetch_unit.sv
// Single-outstanding-request instruction fetch unit with redirect support.
// Presents one instruction at a time to decode and counts accepted instructions.
module fetch_unit #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input logic          clk,
  input logic          rst,
  fetch_unit_if.master bus
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT,
    ST_DROP,
    ST_HOLD
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic        ifValid_q, ifValid_d;
  logic [31:0] ifInstr_q, ifInstr_d;
  logic [31:0] ifPc_q, ifPc_d;
  logic [31:0] fetchCount_q, fetchCount_d;
  logic        imemReq;
  logic [31:0] redirectTarget;

  assign redirectTarget = bus.redirect_pc & 32'hFFFF_FFFC;

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    ifValid_d    = ifValid_q;
    ifInstr_d    = ifInstr_q;
    ifPc_d       = ifPc_q;
    fetchCount_d = fetchCount_q;
    imemReq      = 1'b0;

    // A handshake counts even when a redirect squashes the follow-on fetch.
    if (state_q == ST_HOLD && bus.if_ready) begin
      fetchCount_d = fetchCount_q + 32'd1;
    end

    if (bus.redirect_valid) begin
      pc_d      = redirectTarget;
      ifValid_d = 1'b0;
      ifInstr_d = NOP_INSTR;
      unique case (state_q)
        ST_IDLE: state_d = ST_IDLE;
        ST_HOLD: state_d = ST_IDLE;
        ST_WAIT: state_d = bus.imem_rvalid ? ST_IDLE : ST_DROP;
        ST_DROP: state_d = bus.imem_rvalid ? ST_IDLE : ST_DROP;
        default: state_d = ST_IDLE;
      endcase
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          imemReq = 1'b1;
          state_d = ST_WAIT;
        end
        ST_WAIT: begin
          if (bus.imem_rvalid) begin
            ifInstr_d = bus.imem_rdata;
            ifPc_d    = pc_q;
            ifValid_d = 1'b1;
            pc_d      = pc_q + 32'd4;
            state_d   = ST_HOLD;
          end
        end
        ST_DROP: begin
          if (bus.imem_rvalid) begin
            state_d = ST_IDLE;
          end
        end
        ST_HOLD: begin
          if (bus.if_ready) begin
            imemReq   = 1'b1;
            ifValid_d = 1'b0;
            ifInstr_d = NOP_INSTR;
            state_d   = ST_WAIT;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      pc_q         <= RESET_PC;
      ifValid_q    <= 1'b0;
      ifInstr_q    <= NOP_INSTR;
      ifPc_q       <= 32'd0;
      fetchCount_q <= 32'd0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      ifValid_q    <= ifValid_d;
      ifInstr_q    <= ifInstr_d;
      ifPc_q       <= ifPc_d;
      fetchCount_q <= fetchCount_d;
    end
  end

  assign bus.imem_req    = imemReq & ~rst;
  assign bus.imem_addr   = pc_q;
  assign bus.if_valid    = ifValid_q;
  assign bus.if_instr    = ifInstr_q;
  assign bus.if_pc       = ifPc_q;
  assign bus.opcode      = ifInstr_q[6:0];
  assign bus.funct_3     = ifInstr_q[14:12];
  assign bus.func_7      = ifInstr_q[31:25];
  assign bus.fetch_count = fetchCount_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: a latency-programmable memory responder plus
// scoreboards for issued request addresses and accepted (pc, instr) pairs.
module tb_fetch_unit;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } hs_t;

  localparam logic [31:0] W1  = 32'h0050_0093;
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic clk;
  logic rst;
  fetch_unit_if bus ();
  fetch_unit_if bus2 ();

  int          vectors;
  int          miscompares;
  int          memLatency;
  bit          memFixed;
  hs_t         expHs[$];
  logic [31:0] expReq[$];

  fetch_unit dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  fetch_unit #(.RESET_PC(32'hFFFF_FFFC)) dut2 (
    .clk (clk),
    .rst (rst),
    .bus (bus2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] memWord(input logic [31:0] a);
    return {a[19:0], 12'h013} ^ 32'hA400_5000;
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    vectors++;
    assert (observed === expected) else begin
      miscompares++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  // Advances to just after the next rising edge and drives the decode/redirect inputs.
  task automatic applyStimulus(input logic ready, input logic redir, input logic [31:0] rpc);
    @(posedge clk);
    #1;
    bus.if_ready       = ready;
    bus.redirect_valid = redir;
    bus.redirect_pc    = rpc;
  endtask

  task automatic pushHs(input logic [31:0] pc, input logic [31:0] instr);
    hs_t e;
    e.pc    = pc;
    e.instr = instr;
    expHs.push_back(e);
  endtask

  // Memory model: answers each request memLatency cycles later with one rvalid pulse.
  initial begin
    bit          sawReq;
    logic [31:0] reqAddr;
    int          pend;
    logic [31:0] pendData;
    pend = 0;
    pendData = 32'd0;
    bus.imem_rvalid = 1'b0;
    bus.imem_rdata  = 32'hDEAD_BEEF;
    forever begin
      @(negedge clk);
      sawReq  = bus.imem_req;
      reqAddr = bus.imem_addr;
      @(posedge clk);
      #1;
      bus.imem_rvalid = 1'b0;
      bus.imem_rdata  = 32'hDEAD_BEEF;
      if (pend > 0) begin
        pend--;
        if (pend == 0) begin
          bus.imem_rvalid = 1'b1;
          bus.imem_rdata  = pendData;
        end
      end
      if (sawReq) begin
        pendData = memFixed ? W1 : memWord(reqAddr);
        pend     = memLatency - 1;
        if (pend == 0) begin
          bus.imem_rvalid = 1'b1;
          bus.imem_rdata  = pendData;
        end
      end
    end
  end

  // Zero-wait responder for the wrap-around instance.
  initial begin
    bit sawReq2;
    bus2.imem_rvalid    = 1'b0;
    bus2.imem_rdata     = NOP;
    bus2.redirect_valid = 1'b0;
    bus2.redirect_pc    = 32'd0;
    bus2.if_ready       = 1'b1;
    forever begin
      @(negedge clk);
      sawReq2 = bus2.imem_req;
      @(posedge clk);
      #1;
      bus2.imem_rvalid = sawReq2;
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (bus.imem_req) begin
        vectors++;
        assert (expReq.size() > 0) else begin
          miscompares++;
          $error("[TB] FAIL req_unexpected observed=%h expected=none", bus.imem_addr);
        end
        if (expReq.size() > 0) begin
          vectors--;
          checkOutput("req_addr", bus.imem_addr, expReq.pop_front());
        end
      end
    end
  end

  initial begin
    hs_t e;
    forever begin
      @(negedge clk);
      if (!rst && bus.if_valid && bus.if_ready) begin
        vectors++;
        assert (expHs.size() > 0) else begin
          miscompares++;
          $error("[TB] FAIL hs_unexpected observed=%h expected=none", bus.if_pc);
        end
        if (expHs.size() > 0) begin
          vectors--;
          e = expHs.pop_front();
          checkOutput("hs_pc", bus.if_pc, e.pc);
          checkOutput("hs_instr", bus.if_instr, e.instr);
        end
      end
    end
  end

  initial begin
    logic [31:0] w;
    vectors     = 0;
    miscompares = 0;
    memLatency  = 1;
    memFixed    = 1'b1;
    rst                = 1'b1;
    bus.if_ready       = 1'b0;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc    = 32'd0;

    repeat (2) @(posedge clk);
    @(negedge clk);
    checkOutput("rst_if_valid", 32'(bus.if_valid), 32'd0);
    checkOutput("rst_if_instr", bus.if_instr, NOP);
    checkOutput("rst_if_pc", bus.if_pc, 32'd0);
    checkOutput("rst_fetch_count", bus.fetch_count, 32'd0);
    checkOutput("rst_imem_req", 32'(bus.imem_req), 32'd0);
    checkOutput("rst_imem_addr", bus.imem_addr, 32'd0);
    checkOutput("rst2_imem_addr", bus2.imem_addr, 32'hFFFF_FFFC);

    // c0: release reset, streaming fetch with if_ready high
    applyStimulus(1'b1, 1'b0, 32'd0);
    rst = 1'b0;
    expReq.push_back(32'h0);
    expReq.push_back(32'h4);
    expReq.push_back(32'h8);
    pushHs(32'h0, W1);
    pushHs(32'h4, W1);
    @(negedge clk);
    checkOutput("c0_if_valid", 32'(bus.if_valid), 32'd0);
    checkOutput("wrap_req0", 32'(bus2.imem_req), 32'd1);
    checkOutput("wrap_addr0", bus2.imem_addr, 32'hFFFF_FFFC);
    applyStimulus(1'b1, 1'b0, 32'd0);
    @(negedge clk);
    checkOutput("c1_if_valid", 32'(bus.if_valid), 32'd0);
    applyStimulus(1'b1, 1'b0, 32'd0);
    @(negedge clk);
    checkOutput("first_if_valid", 32'(bus.if_valid), 32'd1);
    checkOutput("first_if_pc", bus.if_pc, 32'h0);
    checkOutput("first_opcode", 32'(bus.opcode), 32'h13);
    checkOutput("first_funct_3", 32'(bus.funct_3), 32'd0);
    checkOutput("wrap_req1", 32'(bus2.imem_req), 32'd1);
    checkOutput("wrap_addr1", bus2.imem_addr, 32'h0);
    checkOutput("wrap_if_pc", bus2.if_pc, 32'hFFFF_FFFC);
    applyStimulus(1'b1, 1'b0, 32'd0);
    applyStimulus(1'b1, 1'b0, 32'd0);
    applyStimulus(1'b0, 1'b0, 32'd0);

    // c6..c10: decode stalls, presented instruction must hold
    for (int i = 0; i < 5; i++) begin
      applyStimulus(1'b0, 1'b0, 32'd0);
      @(negedge clk);
      checkOutput("hold_if_valid", 32'(bus.if_valid), 32'd1);
      checkOutput("hold_if_instr", bus.if_instr, W1);
      checkOutput("hold_if_pc", bus.if_pc, 32'h8);
      checkOutput("hold_imem_req", 32'(bus.imem_req), 32'd0);
      checkOutput("hold_fetch_count", bus.fetch_count, 32'd2);
    end

    // c11: accept, next request then redirect to 0x103 while waiting
    applyStimulus(1'b1, 1'b0, 32'd0);
    memLatency = 3;
    memFixed   = 1'b0;
    expReq.push_back(32'hC);
    pushHs(32'h8, W1);
    applyStimulus(1'b0, 1'b1, 32'h0000_0103);
    @(negedge clk);
    checkOutput("redir_wait_req", 32'(bus.imem_req), 32'd0);
    checkOutput("redir_wait_count", bus.fetch_count, 32'd3);
    applyStimulus(1'b0, 1'b0, 32'd0);
    @(negedge clk);
    checkOutput("drop_req", 32'(bus.imem_req), 32'd0);
    checkOutput("drop_addr", bus.imem_addr, 32'h100);
    checkOutput("drop_if_valid", 32'(bus.if_valid), 32'd0);
    applyStimulus(1'b0, 1'b0, 32'd0);
    memLatency = 1;
    @(negedge clk);
    checkOutput("drop_rvalid_req", 32'(bus.imem_req), 32'd0);
    checkOutput("drop_rvalid_if_valid", 32'(bus.if_valid), 32'd0);
    applyStimulus(1'b0, 1'b0, 32'd0);
    expReq.push_back(32'h100);
    @(negedge clk);
    checkOutput("after_drop_req", 32'(bus.imem_req), 32'd1);
    applyStimulus(1'b0, 1'b0, 32'd0);
    applyStimulus(1'b1, 1'b0, 32'd0);
    memLatency = 2;
    expReq.push_back(32'h104);
    pushHs(32'h100, memWord(32'h100));
    @(negedge clk);
    checkOutput("after_drop_if_pc", bus.if_pc, 32'h100);

    // c19: redirect coincides with the memory response
    applyStimulus(1'b0, 1'b0, 32'd0);
    applyStimulus(1'b0, 1'b1, 32'h0000_0200);
    @(negedge clk);
    checkOutput("coinc_if_valid", 32'(bus.if_valid), 32'd0);
    checkOutput("coinc_req", 32'(bus.imem_req), 32'd0);
    applyStimulus(1'b0, 1'b0, 32'd0);
    memLatency = 1;
    expReq.push_back(32'h200);
    @(negedge clk);
    checkOutput("coinc_next_if_valid", 32'(bus.if_valid), 32'd0);
    checkOutput("coinc_next_req", 32'(bus.imem_req), 32'd1);
    checkOutput("coinc_next_addr", bus.imem_addr, 32'h200);
    applyStimulus(1'b0, 1'b0, 32'd0);
    @(negedge clk);
    checkOutput("coinc_wait_if_valid", 32'(bus.if_valid), 32'd0);

    // c22..c28: three more accepted instructions, then stall with count 7
    applyStimulus(1'b1, 1'b0, 32'd0);
    pushHs(32'h200, memWord(32'h200));
    expReq.push_back(32'h204);
    w = memWord(32'h200);
    @(negedge clk);
    checkOutput("c22_if_valid", 32'(bus.if_valid), 32'd1);
    checkOutput("c22_if_instr", bus.if_instr, w);
    checkOutput("c22_opcode", 32'(bus.opcode), 32'(w[6:0]));
    checkOutput("c22_funct_3", 32'(bus.funct_3), 32'(w[14:12]));
    checkOutput("c22_func_7", 32'(bus.func_7), 32'(w[31:25]));
    checkOutput("c22_fetch_count", bus.fetch_count, 32'd4);
    applyStimulus(1'b1, 1'b0, 32'd0);
    applyStimulus(1'b1, 1'b0, 32'd0);
    pushHs(32'h204, memWord(32'h204));
    expReq.push_back(32'h208);
    applyStimulus(1'b1, 1'b0, 32'd0);
    applyStimulus(1'b1, 1'b0, 32'd0);
    pushHs(32'h208, memWord(32'h208));
    expReq.push_back(32'h20C);
    applyStimulus(1'b0, 1'b0, 32'd0);
    applyStimulus(1'b0, 1'b0, 32'd0);
    @(negedge clk);
    checkOutput("c28_fetch_count", bus.fetch_count, 32'd7);
    checkOutput("c28_if_valid", 32'(bus.if_valid), 32'd1);
    checkOutput("c28_if_pc", bus.if_pc, 32'h20C);
    checkOutput("c28_if_instr", bus.if_instr, memWord(32'h20C));

    // Asynchronous reset in HOLD, away from any clock edge
    #2;
    bus.if_ready = 1'b1;
    rst = 1'b1;
    #1;
    checkOutput("arst_if_valid", 32'(bus.if_valid), 32'd0);
    checkOutput("arst_if_instr", bus.if_instr, NOP);
    checkOutput("arst_if_pc", bus.if_pc, 32'd0);
    checkOutput("arst_fetch_count", bus.fetch_count, 32'd0);
    checkOutput("arst_imem_req", 32'(bus.imem_req), 32'd0);
    checkOutput("arst_imem_addr", bus.imem_addr, 32'd0);
    checkOutput("arst2_imem_addr", bus2.imem_addr, 32'hFFFF_FFFC);
    applyStimulus(1'b1, 1'b0, 32'd0);
    @(negedge clk);
    checkOutput("arst_edge_count", bus.fetch_count, 32'd0);
    checkOutput("arst_edge_req", 32'(bus.imem_req), 32'd0);
    checkOutput("hs_queue_drained", 32'(expHs.size()), 32'd0);
    checkOutput("req_queue_drained", 32'(expReq.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
